// File: rtl/spi_slave_mode0_rx.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/CS and assembles FRAME_BITS-wide frames.
// Optional MISO response path is enabled by defining SPI_SLAVE_MISO_EN.
module spi_slave_mode0_rx #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  CS,
  output logic                  MISO,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    FULL
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [FRAME_BITS-1:0]  rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   overrun;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  // CS synchronizer resets low so a frame already running at reset release stays invisible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

`ifdef SPI_SLAVE_MISO_EN
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] resp_buf;
  logic [FRAME_BITS-1:0] tx_first;

  // A load coinciding with frame start bypasses the buffer
  assign tx_first = tx_load ? tx_data : resp_buf;

  // Response buffer: emptied when a frame takes it, so unloaded frames answer zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_buf <= '0;
    end else if (state == IDLE && cs_fall) begin
      resp_buf <= '0;
    end else if (tx_load) begin
      resp_buf <= tx_data;
    end
  end
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_load};
  assign MISO      = 1'b0;
`endif

  // Frame FSM; CS edges take priority over SCLK edges in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      tx_shift  <= '0;
      MISO      <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          busy <= 1'b0;
          if (cs_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
`ifdef SPI_SLAVE_MISO_EN
            tx_shift <= tx_first;
            MISO     <= tx_first[FRAME_BITS-1];
`endif
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (bit_cnt == CNT_W'(FRAME_BITS)) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
`ifdef SPI_SLAVE_MISO_EN
            MISO <= 1'b0;
`endif
          end else if (bit_cnt == CNT_W'(FRAME_BITS)) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            state    <= FULL;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
`ifdef SPI_SLAVE_MISO_EN
            if (sclk_fall) begin
              tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
              MISO     <= tx_shift[FRAME_BITS-2];
            end
`endif
          end
        end
        FULL: begin
          if (cs_rise) begin
            frame_err <= overrun;
            overrun   <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
            MISO <= 1'b0;
`endif
          end else if (sclk_rise) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
